bus_slave_adapter: RTL and testbench
====================================

// Module: bus_slave_adapter
// PURPOSE
// Protocol front-end for peripheral register blocks (e.g. UART). Converts one of three
// system-bus slave protocols (APB, AHB-Lite, Avalon-MM) into the simple register
// interface (sif: addr/we/wd/re/rd) that the peripheral core uses. Protocol is chosen
// at elaboration by BUS_TYPE. Inputs of unselected buses are ignored; their outputs are held at 0.
// PARAMETERS
// BUS_TYPE  "APB"  selected protocol: "APB" | "AHB" | "AVALON"; any other value -> $fatal
// ADDR_W    32     address width, all buses and sif
// DATA_W    32     data width, all buses and sif
// PORTS
// clk          in   1       single clock for all logic
// rstn         in   1       async reset, ACTIVE-HIGH (1 = reset), codebase port name kept
// psel,penable,pwrite  in 1 APB control
// paddr        in   ADDR_W  APB address
// pwdata       in   DATA_W  APB write data
// prdata       out  DATA_W  APB read data
// pready       out  1       APB ready
// pslverr      out  1       APB error, always 0
// hsel,hwrite  in   1       AHB select / direction
// htrans       in   2       AHB transfer type (NONSEQ=2, SEQ=3 start a transfer)
// haddr        in   ADDR_W  AHB address
// hwdata       in   DATA_W  AHB write data (data phase)
// hready       in   1       AHB global ready
// hrdata       out  DATA_W  AHB read data
// hreadyout    out  1       AHB slave ready
// hresp        out  1       AHB response, always 0 (OKAY)
// address      in   ADDR_W  Avalon address
// read,write   in   1       Avalon strobes
// writedata    in   DATA_W  Avalon write data
// readdata     out  DATA_W  Avalon read data
// readdatavalid out 1       Avalon read data valid
// waitrequest  out  1       Avalon wait, always 0
// sif_addr     out  ADDR_W  register address to core
// sif_we       out  1       one-cycle write strobe
// sif_wd       out  DATA_W  write data
// sif_re       out  1       one-cycle read strobe
// sif_rd       in   DATA_W  core read data, valid exactly 1 cycle after sif_re
// BEHAVIOUR
// - Reset: all outputs 0 except pready=0, hreadyout=1. Reset mid-transfer aborts it; no strobes
//   issued while rstn=1; after release, adapter idle and accepts a new transfer next edge.
// - sif_we/sif_re never both 1; each strobe lasts exactly 1 cycle per bus transfer.
// - APB: setup (psel&!penable) -> nothing. First access cycle: sif_addr=paddr, sif_we=pwrite
//   (sif_wd=pwdata) or sif_re=!pwrite; pready=0. Next cycle: pready=1, prdata=sif_rd
//   (reads). Exactly one wait state. psel dropped before pready -> FSM returns IDLE, no
//   second strobe. FSM: IDLE -> ACCESS -> DONE -> IDLE.
// - AHB: address phase accepted when hsel&htrans[1]&hready; haddr/hwrite registered.
//   Write data phase: sif_we=1, sif_wd=hwdata, sif_addr=reg addr, hreadyout=1 (zero wait).
//   Read data phase: cycle1 sif_re=1, hreadyout=0; cycle2 hrdata=sif_rd, hreadyout=1.
//   New address phase during final data-phase cycle is accepted (pipelining). IDLE/BUSY
//   htrans or hsel=0 -> no strobe, hreadyout=1.
// - Avalon: write -> sif_we same cycle (combinational pass of address/writedata).
//   read -> sif_re same cycle; next cycle readdatavalid=1, readdata=sif_rd (fixed latency 1).
//   read&write together: write wins, read ignored.
// - Read data outputs hold last value between transfers; only sif_rd is sampled.
// TESTING
// - APB write 0x04<=0xA5A5_0001 -> one sif_we pulse, sif_addr=0x04, sif_wd=0xA5A5_0001,
//   pready 1 cycle later, pslverr=0.
// - APB read 0x08, core sif_rd=0x55 -> sif_re pulse, prdata=0x55 with pready=1 after 1 wait.
// - AHB back-to-back NONSEQ write 0x00<=0x12 then read 0x00 (core returns 0x12) ->
//   one sif_we, one sif_re, hreadyout low exactly 1 cycle on read, hrdata=0x12, hresp=0.
// - Avalon write 0x0C<=0xFF then read 0x0C (core 0xFF) -> readdatavalid one cycle after
//   read, readdata=0xFF, waitrequest always 0.
// - Assert rstn during AHB read wait cycle -> no further strobes, hreadyout=1, hrdata=0;
//   after release a fresh read completes normally.
// - Each BUS_TYPE: toggle unselected bus inputs randomly -> no sif strobes, their outputs 0.

Source files
------------

// File: rtl/bus_slave_adapter.sv
// bus_slave_adapter: adapts an APB, AHB-Lite or Avalon-MM slave port to the simple sif register interface
module bus_slave_adapter #(
  parameter string BUS_TYPE = "APB",
  parameter int    ADDR_W   = 32,
  parameter int    DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              hsel,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  output logic [ADDR_W-1:0] sif_addr,
  output logic              sif_we,
  output logic [DATA_W-1:0] sif_wd,
  output logic              sif_re,
  input  logic [DATA_W-1:0] sif_rd
);
  logic unused_in;
  assign unused_in = ^{psel, penable, pwrite, paddr, pwdata, hsel, hwrite, htrans, haddr, hwdata,
                       hready, address, read, write, writedata, sif_rd};
  if (BUS_TYPE == "APB") begin : g_apb
    typedef enum logic [1:0] {A_IDLE, A_ACCESS, A_DONE} apb_t;
    apb_t st, nx;
    logic go, was_rd;
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clk or posedge rstn)
      if (rstn) begin
        st <= A_IDLE;
        was_rd <= 1'b0;
        rd_q <= '0;
      end else begin
        st <= nx;
        if (st == A_ACCESS) was_rd <= !pwrite;
        if (st == A_DONE && was_rd) rd_q <= sif_rd;
      end
    // psel dropping in ACCESS abandons the transfer before any strobe
    always_comb
      nx = st == A_IDLE   ? (psel && !penable ? A_ACCESS : A_IDLE) :
           st == A_ACCESS ? (!psel ? A_IDLE : penable ? A_DONE : A_ACCESS) : A_IDLE;
    assign go       = st == A_ACCESS && psel && penable;
    assign sif_we   = go && pwrite;
    assign sif_re   = go && !pwrite;
    assign sif_addr = go ? paddr : '0;
    assign sif_wd   = sif_we ? pwdata : '0;
    assign pready   = st == A_DONE;
    assign prdata   = (st == A_DONE && was_rd) ? sif_rd : rd_q;
    assign pslverr  = 1'b0;
    assign {hrdata, hreadyout, hresp, readdata, readdatavalid, waitrequest} = '0;
  end else if (BUS_TYPE == "AHB") begin : g_ahb
    typedef enum logic [1:0] {H_IDLE, H_WR, H_RD1, H_RD2} ahb_t;
    ahb_t st, nx;
    logic acc;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] rd_q;
    assign acc = hsel && htrans[1] && hready && st != H_RD1;
    always_ff @(posedge clk or posedge rstn)
      if (rstn) begin
        st <= H_IDLE;
        a_addr <= '0;
        rd_q <= '0;
      end else begin
        st <= nx;
        if (acc) a_addr <= haddr;
        if (st == H_RD2) rd_q <= sif_rd;
      end
    // direction is folded into the data-phase state at address acceptance
    always_comb
      nx = st == H_RD1 ? H_RD2 : acc ? (hwrite ? H_WR : H_RD1) : H_IDLE;
    assign sif_we    = st == H_WR;
    assign sif_re    = st == H_RD1;
    assign sif_addr  = (sif_we || sif_re) ? a_addr : '0;
    assign sif_wd    = sif_we ? hwdata : '0;
    assign hreadyout = st != H_RD1;
    assign hrdata    = st == H_RD2 ? sif_rd : rd_q;
    assign hresp     = 1'b0;
    assign {prdata, pready, pslverr, readdata, readdatavalid, waitrequest} = '0;
  end else if (BUS_TYPE == "AVALON") begin : g_avalon
    logic w, r, rv;
    logic [DATA_W-1:0] rd_q;
    // strobes pass straight through, so reset must gate them explicitly
    assign w = write && !rstn;
    assign r = read && !write && !rstn;
    always_ff @(posedge clk or posedge rstn)
      if (rstn) begin
        rv <= 1'b0;
        rd_q <= '0;
      end else begin
        rv <= r;
        if (rv) rd_q <= sif_rd;
      end
    assign sif_we        = w;
    assign sif_re        = r;
    assign sif_addr      = (w || r) ? address : '0;
    assign sif_wd        = w ? writedata : '0;
    assign readdatavalid = rv;
    assign readdata      = rv ? sif_rd : rd_q;
    assign waitrequest   = 1'b0;
    assign {prdata, pready, pslverr, hrdata, hreadyout, hresp} = '0;
  end else begin : g_bad
    $fatal(1, "bus_slave_adapter: unsupported BUS_TYPE %s", BUS_TYPE);
  end
endmodule

// File: tb/tb_bus_slave_adapter.sv
// tb_bus_slave_adapter: one adapter per protocol, scoreboard checked against a memory-model core
module tb_bus_slave_adapter;
  typedef struct packed {
    logic [31:0] prdata; logic pready; logic pslverr;
    logic [31:0] hrdata; logic hreadyout; logic hresp;
    logic [31:0] readdata; logic readdatavalid; logic waitrequest;
    logic [31:0] sif_addr; logic sif_we; logic [31:0] sif_wd; logic sif_re;
  } outs_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wd;} exp_t;

  logic clk = 0, rstn = 1;
  logic psel = 0, penable = 0, pwrite = 0, hsel = 0, hwrite = 0, hready_n = 0, read = 0, write = 0;
  logic [1:0] htrans = 0;
  logic [31:0] paddr = 0, pwdata = 0, haddr = 0, hwdata = 0, address = 0, writedata = 0, sif_rd = 0;
  logic hready;
  outs_t op, oh, ov;
  int phase = 0, checks = 0, failures = 0;
  exp_t sq[$];
  logic [31:0] rq[$];
  logic [31:0] ref_mem[8], core_mem[8];
  logic [31:0] last_p = 0, pend_wd = 0;
  logic prev_low = 0;

  always #5 clk = ~clk;
  assign hready = phase == 1 ? oh.hreadyout : hready_n;

  bus_slave_adapter #(.BUS_TYPE("APB")) u_apb (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(op.prdata), .pready(op.pready), .pslverr(op.pslverr), .hsel(hsel), .hwrite(hwrite), .htrans(htrans),
    .haddr(haddr), .hwdata(hwdata), .hready(hready), .hrdata(op.hrdata), .hreadyout(op.hreadyout), .hresp(op.hresp),
    .address(address), .read(read), .write(write), .writedata(writedata), .readdata(op.readdata),
    .readdatavalid(op.readdatavalid), .waitrequest(op.waitrequest), .sif_addr(op.sif_addr), .sif_we(op.sif_we),
    .sif_wd(op.sif_wd), .sif_re(op.sif_re), .sif_rd(sif_rd));
  bus_slave_adapter #(.BUS_TYPE("AHB")) u_ahb (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(oh.prdata), .pready(oh.pready), .pslverr(oh.pslverr), .hsel(hsel), .hwrite(hwrite), .htrans(htrans),
    .haddr(haddr), .hwdata(hwdata), .hready(hready), .hrdata(oh.hrdata), .hreadyout(oh.hreadyout), .hresp(oh.hresp),
    .address(address), .read(read), .write(write), .writedata(writedata), .readdata(oh.readdata),
    .readdatavalid(oh.readdatavalid), .waitrequest(oh.waitrequest), .sif_addr(oh.sif_addr), .sif_we(oh.sif_we),
    .sif_wd(oh.sif_wd), .sif_re(oh.sif_re), .sif_rd(sif_rd));
  bus_slave_adapter #(.BUS_TYPE("AVALON")) u_av (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(ov.prdata), .pready(ov.pready), .pslverr(ov.pslverr), .hsel(hsel), .hwrite(hwrite), .htrans(htrans),
    .haddr(haddr), .hwdata(hwdata), .hready(hready), .hrdata(ov.hrdata), .hreadyout(ov.hreadyout), .hresp(ov.hresp),
    .address(address), .read(read), .write(write), .writedata(writedata), .readdata(ov.readdata),
    .readdatavalid(ov.readdatavalid), .waitrequest(ov.waitrequest), .sif_addr(ov.sif_addr), .sif_we(ov.sif_we),
    .sif_wd(ov.sif_wd), .sif_re(ov.sif_re), .sif_rd(sif_rd));

  function automatic outs_t act();
    return phase == 0 ? op : phase == 1 ? oh : ov;
  endfunction

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic pop_rd(input string n, input logic [31:0] v);
    if (rq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected response actual=%0h expected=none", n, v);
    end else chk(n, v, rq.pop_front());
  endtask

  // core: memory answering reads exactly one cycle later, junk otherwise
  always @(posedge clk) begin
    outs_t a;
    a = act();
    sif_rd <= a.sif_re ? core_mem[a.sif_addr[4:2]] : $urandom;
    if (rstn) for (int i = 0; i < 8; i++) core_mem[i] <= 0;
    else if (a.sif_we) core_mem[a.sif_addr[4:2]] <= a.sif_wd;
  end

  always @(negedge clk) begin
    outs_t a;
    exp_t e;
    a = act();
    chk("apb_unselected_zero", {op.hrdata, op.hreadyout, op.hresp, op.readdata, op.readdatavalid, op.waitrequest}, 0);
    chk("ahb_unselected_zero", {oh.prdata, oh.pready, oh.pslverr, oh.readdata, oh.readdatavalid, oh.waitrequest}, 0);
    chk("avl_unselected_zero", {ov.prdata, ov.pready, ov.pslverr, ov.hrdata, ov.hreadyout, ov.hresp}, 0);
    chk("error_outputs_zero", {op.pslverr, oh.hresp, ov.waitrequest}, 0);
    if (rstn) prev_low = 0;
    else begin
      if (a.sif_we || a.sif_re) begin
        chk("we_re_exclusive", a.sif_we & a.sif_re, 0);
        if (sq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL strobe unexpected actual we=%0b re=%0b addr=%0h expected=none", a.sif_we, a.sif_re, a.sif_addr);
        end else begin
          e = sq.pop_front();
          chk("strobe_kind", {a.sif_we, a.sif_re}, {e.we, !e.we});
          chk("sif_addr", a.sif_addr, e.addr);
          if (e.we) chk("sif_wd", a.sif_wd, e.wd);
        end
      end
      if (phase == 0 && a.pready) pop_rd("prdata", a.prdata);
      if (phase == 1) begin
        if (prev_low && !a.hreadyout) chk("ahb_one_wait", a.hreadyout, 1);
        if (prev_low && a.hreadyout) pop_rd("hrdata", a.hrdata);
        prev_low = !a.hreadyout;
      end
      if (phase == 2 && a.readdatavalid) pop_rd("readdata", a.readdata);
    end
  end

  // every cycle the buses not under test get random traffic
  task automatic tick();
    @(posedge clk);
    #1;
    if (phase != 0) begin
      psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom); paddr = $urandom; pwdata = $urandom;
    end
    if (phase != 1) begin
      hsel = 1'($urandom); hwrite = 1'($urandom); htrans = 2'($urandom); haddr = $urandom; hwdata = $urandom;
      hready_n = 1'($urandom);
    end
    if (phase != 2) begin
      address = $urandom; read = 1'($urandom); write = 1'($urandom); writedata = $urandom;
    end
  endtask

  function automatic logic [31:0] raddr();
    return 32'($urandom_range(0, 7)) << 2;
  endfunction

  task automatic start(input int p);
    rstn = 1;
    phase = p;
    {psel, penable, pwrite, paddr, pwdata, hsel, hwrite, htrans, haddr, hwdata, address, read, write, writedata} = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 0;
    last_p = 0;
    pend_wd = 0;
    tick();
    @(negedge clk);
    chk("rst_sif", {op.sif_we, op.sif_re, oh.sif_we, oh.sif_re, ov.sif_we, ov.sif_re}, 0);
    chk("rst_sif_bus", {op.sif_addr, op.sif_wd, oh.sif_addr, ov.sif_addr}, 0);
    chk("rst_apb", {op.pready, op.prdata}, 0);
    chk("rst_ahb", {oh.hreadyout, oh.hrdata}, {1'b1, 32'h0});
    chk("rst_avl", {ov.readdatavalid, ov.readdata}, 0);
    tick();
    rstn = 0;
  endtask

  task automatic drain(input string n);
    repeat (4) tick();
    chk({n, "_strobes_drained"}, sq.size(), 0);
    chk({n, "_responses_drained"}, rq.size(), 0);
  endtask

  task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    sq.push_back({wr, a, d});
    if (wr) ref_mem[a[4:2]] = d;
    else last_p = ref_mem[a[4:2]];
    rq.push_back(last_p);
    tick(); psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    tick(); penable = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!op.pready && n < 5);
    chk("apb_pready", op.pready, 1);
    chk("apb_wait_cycles", n, 2);
    tick(); psel = 0; penable = 0;
  endtask

  task automatic ahb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit resp);
    int n;
    sq.push_back({wr, a, d});
    if (wr) ref_mem[a[4:2]] = d;
    else if (resp) rq.push_back(ref_mem[a[4:2]]);
    tick(); hsel = 1; htrans = {1'b1, 1'($urandom)}; haddr = a; hwrite = wr; hwdata = pend_wd;
    n = 0;
    @(negedge clk);
    while (!oh.hreadyout && n < 4) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("ahb_addr_accepted", oh.hreadyout, 1);
    pend_wd = wr ? d : $urandom;
  endtask

  task automatic ahb_idle();
    tick(); hsel = 1'($urandom); htrans = {1'b0, 1'($urandom)}; haddr = $urandom; hwrite = 1'($urandom);
    hwdata = pend_wd;
    pend_wd = $urandom;
  endtask

  task automatic av_cmd(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (w) begin
      sq.push_back({1'b1, a, d});
      ref_mem[a[4:2]] = d;
    end else if (r) begin
      sq.push_back({1'b0, a, 32'h0});
      rq.push_back(ref_mem[a[4:2]]);
    end
    tick(); read = r; write = w; address = a; writedata = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    start(0);
    apb_xfer(1, 32'h04, 32'hA5A5_0001);
    apb_xfer(1, 32'h08, 32'h55);
    apb_xfer(0, 32'h08, 0);
    tick(); psel = 1; penable = 0; paddr = 32'h0C; pwrite = 1;
    tick(); psel = 0;
    tick();
    repeat (20) begin
      apb_xfer(1'($urandom), raddr(), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain("apb");

    start(1);
    ahb_xfer(1, 32'h00, 32'h12, 1);
    ahb_xfer(0, 32'h00, 0, 1);
    repeat (3) ahb_idle();
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) ahb_idle();
      else ahb_xfer(1'($urandom), raddr(), $urandom, 1);
    end
    repeat (3) ahb_idle();
    ahb_xfer(0, 32'h04, 0, 0);
    ahb_idle();
    @(negedge clk);
    #1 rstn = 1;
    for (int i = 0; i < 8; i++) ref_mem[i] = 0;
    @(negedge clk);
    chk("ahb_rst_strobes", {oh.sif_we, oh.sif_re}, 0);
    chk("ahb_rst_hreadyout", oh.hreadyout, 1);
    chk("ahb_rst_hrdata", oh.hrdata, 0);
    tick();
    rstn = 0;
    ahb_xfer(1, 32'h10, 32'hBEEF_0042, 1);
    ahb_xfer(0, 32'h10, 0, 1);
    repeat (3) ahb_idle();
    drain("ahb");

    start(2);
    av_cmd(0, 1, 32'h0C, 32'hFF);
    av_cmd(1, 0, 32'h0C, 0);
    av_cmd(0, 0, 0, 0);
    av_cmd(1, 1, 32'h0C, 32'h77);
    av_cmd(1, 0, 32'h0C, 0);
    repeat (40) av_cmd(1'($urandom), 1'($urandom), raddr(), $urandom);
    av_cmd(0, 0, 0, 0);
    drain("avalon");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
